keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : keypad_scanner
// Description : 4x3 matrix keypad scanner with row strobing, press/release
//               debounce and a one-cycle key strobe per accepted press.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int               DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] c_div_max = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       c_deb     = 8'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  logic [2:0]       r_col_meta;
  logic [2:0]       r_col_s;
  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic [1:0]       r_row;
  logic [1:0]       r_cand;
  logic [7:0]       r_press_cnt;
  logic [7:0]       r_rel_cnt;
  logic [3:0]       r_key;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_tick;
  logic             w_none;
  logic             w_single;
  logic [1:0]       w_col_idx;
  logic [7:0]       w_press_next;
  logic [7:0]       w_rel_next;

  // Map a (row, column) position to its key code.
  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = 4'hA;
        2'd1:    code = 4'h0;
        default: code = 4'hB;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_meta <= 3'b111;
      r_col_s    <= 3'b111;
    end else begin
      r_col_meta <= col_n;
      r_col_s    <= r_col_meta;
    end
  end

  // Free-running row dwell divider; tick marks the last count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == c_div_max) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick       = (r_div == c_div_max);
  assign w_press_next = r_press_cnt + 8'd1;
  assign w_rel_next   = r_rel_cnt + 8'd1;

  // Classify the synchronized column sample: none, single (with index) or multi.
  always_comb begin
    w_none    = (r_col_s == 3'b111);
    w_single  = 1'b0;
    w_col_idx = 2'd0;
    case (r_col_s)
      3'b110:  begin w_single = 1'b1; w_col_idx = 2'd0; end
      3'b101:  begin w_single = 1'b1; w_col_idx = 2'd1; end
      3'b011:  begin w_single = 1'b1; w_col_idx = 2'd2; end
      default: begin w_single = 1'b0; w_col_idx = 2'd0; end
    endcase
  end

  // Scan/debounce FSM with registered key, strobe and held outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_row       <= 2'd0;
      r_cand      <= 2'd0;
      r_press_cnt <= 8'd0;
      r_rel_cnt   <= 8'd0;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_tick) begin
            if (w_single) begin
              r_cand      <= w_col_idx;
              r_press_cnt <= 8'd1;
              if (c_deb == 8'd1) begin
                r_state     <= ST_EMIT;
                r_key       <= map_key(r_row, w_col_idx);
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_state <= ST_DEBOUNCE;
              end
            end else begin
              r_row <= r_row + 2'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_tick) begin
            if (w_single && (w_col_idx == r_cand)) begin
              r_press_cnt <= w_press_next;
              if (w_press_next == c_deb) begin
                r_state     <= ST_EMIT;
                r_key       <= map_key(r_row, r_cand);
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end
            end else begin
              r_state     <= ST_SCAN;
              r_press_cnt <= 8'd0;
              r_row       <= r_row + 2'd1;
            end
          end
        end
        ST_EMIT: begin
          // Strobe lasts exactly this one cycle; wait for release from here.
          r_state   <= ST_RELEASE;
          r_rel_cnt <= 8'd0;
        end
        ST_RELEASE: begin
          if (w_tick) begin
            if (w_none) begin
              if (w_rel_next == c_deb) begin
                r_state     <= ST_SCAN;
                r_rel_cnt   <= 8'd0;
                r_press_cnt <= 8'd0;
                r_key_held  <= 1'b0;
                r_row       <= r_row + 2'd1;
              end else begin
                r_rel_cnt <= w_rel_next;
              end
            end else begin
              r_rel_cnt <= 8'd0;
            end
          end
        end
        default: begin
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign row_n     = ~(4'b0001 << r_row);
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire
